// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: queues rectangle commands in a small FIFO and expands
// each one into a row-major stream of one pixel write per clock for the
// 160x120 VGA adapter. Pixels outside the screen still take their cycle but
// are not plotted, so the timing does not depend on position.
module rect_fill_engine #(
    parameter int SCREEN_W   = 160,
    parameter int SCREEN_H   = 120,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_x,
    input  logic [7:0] cmd_y,
    input  logic [7:0] cmd_w,
    input  logic [7:0] cmd_h,
    input  logic [2:0] cmd_colour,
    input  logic       flush,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [8:0]       SCREEN_W_C = 9'(SCREEN_W);
    localparam logic [8:0]       SCREEN_H_C = 9'(SCREEN_H);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

    typedef struct packed {
        logic [7:0] ox;
        logic [7:0] oy;
        logic [7:0] w;
        logic [7:0] h;
        logic [2:0] clr;
    } cmd_t;

    cmd_t mem [FIFO_DEPTH];
    cmd_t cmd_in;
    cmd_t head;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]       ox_q, ox_d, oy_q, oy_d, w_q, w_d, h_q, h_d;
    logic [2:0]       clr_q, clr_d;
    logic [7:0]       col_q, col_d, row_q, row_d;
    logic [7:0]       x_q, x_d;
    logic [6:0]       y_q, y_d;
    logic [2:0]       colour_q, colour_d;
    logic             plot_q, plot_d, done_q, done_d, busy_q, busy_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             push, pop;
    logic [8:0]       px, py;

    assign cmd_in = {cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour};

    // Next-state logic: FIFO bookkeeping, rectangle walker and output values.
    always_comb begin
        // NOTE: every _d starts from its _q so no path can leave a latch behind.
        state_d  = state_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        w_d      = w_q;
        h_d      = h_q;
        clr_d    = clr_q;
        col_d    = col_q;
        row_d    = row_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        done_d   = 1'b0;
        pop      = 1'b0;
        push     = cmd_valid && cmd_ready_q && !flush;
        head     = mem[rd_ptr_q];
        px       = {1'b0, ox_q} + {1'b0, col_q};
        py       = {1'b0, oy_q} + {1'b0, row_q};

        unique case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop   = 1'b1;
                    ox_d  = head.ox;
                    oy_d  = head.oy;
                    w_d   = head.w;
                    h_d   = head.h;
                    clr_d = head.clr;
                    col_d = '0;
                    row_d = '0;
                    state_d = (head.w == '0 || head.h == '0) ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                x_d      = px[7:0];
                y_d      = py[6:0];
                colour_d = clr_q;
                plot_d   = (px < SCREEN_W_C) && (py < SCREEN_H_C);
                if (col_q == w_q - 8'd1) begin
                    col_d = '0;
                    if (row_q == h_q - 8'd1) begin
                        state_d = S_DONE;
                    end else begin
                        row_d = row_q + 8'd1;
                    end
                end else begin
                    col_d = col_q + 8'd1;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (!push && pop) count_d = count_q - CNT_W'(1);

        if (flush) begin
            state_d  = S_IDLE;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            x_d      = x_q;
            y_d      = y_q;
            colour_d = colour_q;
            plot_d   = 1'b0;
            done_d   = 1'b0;
        end

        cmd_ready_d = (count_d < DEPTH_C);
        busy_d      = (state_d != S_IDLE) || (count_d != '0);
    end

    // Command storage; write-only on push, read combinationally at the head.
    always_ff @(posedge clock) begin
        // NOTE: the FIFO array is not reset; empty/full come from the reset pointers and count.
        if (push) mem[wr_ptr_q] <= cmd_in;
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (reset) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
            w_q         <= '0;
            h_q         <= '0;
            clr_q       <= '0;
            col_q       <= '0;
            row_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            colour_q    <= '0;
            plot_q      <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ox_q        <= ox_d;
            oy_q        <= oy_d;
            w_q         <= w_d;
            h_q         <= h_d;
            clr_q       <= clr_d;
            col_q       <= col_d;
            row_q       <= row_d;
            x_q         <= x_d;
            y_q         <= y_d;
            colour_q    <= colour_d;
            plot_q      <= plot_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign colour    = colour_q;
    assign plot      = plot_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign cmd_ready = cmd_ready_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed bench for rect_fill_engine: fill, clipping, zero size, FIFO
// back-pressure, flush and reset, with hand-derived expected values.
module tb_rect_fill_engine;

    logic       clock = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_x, cmd_y, cmd_w, cmd_h;
    logic [2:0] cmd_colour;
    logic       flush;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    rect_fill_engine dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_w      (cmd_w),
        .cmd_h      (cmd_h),
        .cmd_colour (cmd_colour),
        .flush      (flush),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are examined 1 ns after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input int ox, input int oy, input int w, input int h, input int clr);
        cmd_valid  = 1'b1;
        cmd_x      = 8'(ox);
        cmd_y      = 8'(oy);
        cmd_w      = 8'(w);
        cmd_h      = 8'(h);
        cmd_colour = 3'(clr);
    endtask

    // Expected pixel idx (row-major) of a rectangle, as {done, plot, x, y, colour}.
    task automatic check_pixel(input int ox, input int oy, input int w, input int clr, input int idx);
        int px, py;
        logic [8:0] pxv, pyv;
        logic [2:0] cv;
        logic p;
        logic [19:0] exp_v, got_v;
        px  = ox + idx % w;
        py  = oy + idx / w;
        pxv = 9'(px);
        pyv = 9'(py);
        cv  = 3'(clr);
        p   = (px < 160) && (py < 120);
        exp_v = {1'b0, p, pxv[7:0], pyv[6:0], cv};
        got_v = {done, plot, x, y, colour};
        check($sformatf("pixel(%0d,%0d)", px, py), {12'd0, got_v}, {12'd0, exp_v});
    endtask

    // Call when the next edge produces the first pixel of the rectangle.
    task automatic fill_check(input int ox, input int oy, input int w, input int h, input int clr,
                              output int nplot);
        nplot = 0;
        for (int i = 0; i < w * h; i++) begin
            tick();
            check_pixel(ox, oy, w, clr, i);
            if (plot) nplot++;
        end
    endtask

    // DONE cycle then IDLE cycle after the last pixel.
    task automatic end_check(input logic exp_busy);
        tick();
        check("done_pulse", {30'd0, done, plot}, 32'd2);
        check("busy_at_done", {31'd0, busy}, {31'd0, exp_busy});
        tick();
        check("done_clear", {30'd0, done, plot}, 32'd0);
        check("busy_after_done", {31'd0, busy}, {31'd0, exp_busy});
    endtask

    int np;
    int n;
    int plots;
    int dones;

    initial begin
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        flush      = 1'b0;
        cmd_x      = '0;
        cmd_y      = '0;
        cmd_w      = '0;
        cmd_h      = '0;
        cmd_colour = '0;

        // Reset values.
        tick();
        tick();
        check("rst_xyc", {13'd0, x, y, colour}, 32'd0);
        check("rst_plot_done_busy", {29'd0, plot, done, busy}, 32'd0);
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        reset = 1'b0;
        tick();

        // Test 1: 16x2 rectangle at (76,110), colour 7.
        offer(76, 110, 16, 2, 7);
        tick();
        cmd_valid = 1'b0;
        check("t1_busy_after_push", {31'd0, busy}, 32'd1);
        check("t1_ready_after_push", {31'd0, cmd_ready}, 32'd1);
        tick();
        check("t1_no_plot_at_pop", {30'd0, plot, done}, 32'd0);
        fill_check(76, 110, 16, 2, 7, np);
        check("t1_plot_count", np, 32);
        end_check(1'b0);

        // Test 2: clipped 8x4 rectangle at (155,118), colour 2.
        offer(155, 118, 8, 4, 2);
        tick();
        cmd_valid = 1'b0;
        tick();
        fill_check(155, 118, 8, 4, 2, np);
        check("t2_plot_count", np, 10);
        end_check(1'b0);

        // Test 3: zero-width command then a 1x1.
        offer(10, 10, 0, 5, 1);
        tick();
        offer(20, 20, 1, 1, 4);
        tick();
        cmd_valid = 1'b0;
        check("t3_idle_pop", {30'd0, plot, done}, 32'd0);
        tick();
        check("t3_zero_done", {30'd0, done, plot}, 32'd2);
        check("t3_hold_xyc", {13'd0, x, y, colour}, {13'd0, 8'd162, 7'd121, 3'd2});
        check("t3_busy_queued", {31'd0, busy}, 32'd1);
        tick();
        check("t3_zero_done_clear", {30'd0, done, plot}, 32'd0);
        fill_check(20, 20, 1, 1, 4, np);
        check("t3_plot_count", np, 1);
        end_check(1'b0);

        // Test 4: six 16x16 commands offered back to back.
        offer(0, 0, 16, 16, 1);
        check("t4_ready_e0", {31'd0, cmd_ready}, 32'd1);
        tick();
        offer(20, 10, 16, 16, 2);
        tick();
        check("t4_ready_e1", {31'd0, cmd_ready}, 32'd1);
        dones = 0;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    fill_check(k * 20, k * 10, 16, 16, k + 1, np);
                    check("t4_plot_count", np, 256);
                    end_check(k < 5);
                    dones++;
                end
            end
            begin
                for (int k = 2; k < 5; k++) begin
                    offer(k * 20, k * 10, 16, 16, k + 1);
                    tick();
                    check("t4_ready", {31'd0, cmd_ready}, (k < 4) ? 32'd1 : 32'd0);
                end
                offer(100, 50, 16, 16, 6);
                n = 0;
                while (cmd_ready !== 1'b1 && n < 400) begin
                    tick();
                    n++;
                end
                check("t4_ready_wait", n, 255);
                tick();
                cmd_valid = 1'b0;
                check("t4_sixth_accepted", {31'd0, cmd_ready}, 32'd0);
            end
        join
        check("t4_done_count", dones, 6);

        // Test 5: flush on the 100th pixel with two commands queued.
        offer(40, 30, 16, 16, 6);
        tick();
        offer(0, 0, 4, 4, 1);
        tick();
        offer(0, 0, 4, 4, 2);
        tick();
        cmd_valid = 1'b0;
        check_pixel(40, 30, 16, 6, 0);
        for (int i = 1; i < 100; i++) begin
            tick();
            check_pixel(40, 30, 16, 6, i);
        end
        flush = 1'b1;
        offer(1, 1, 3, 3, 7);
        tick();
        flush     = 1'b0;
        cmd_valid = 1'b0;
        check("t5_flush_plot_done", {30'd0, plot, done}, 32'd0);
        check("t5_flush_busy", {31'd0, busy}, 32'd0);
        check("t5_flush_ready", {31'd0, cmd_ready}, 32'd1);
        plots = 0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (plot) plots++;
            if (done) dones++;
        end
        check("t5_quiet_plots", plots, 0);
        check("t5_quiet_dones", dones, 0);
        offer(30, 40, 2, 2, 5);
        tick();
        cmd_valid = 1'b0;
        tick();
        fill_check(30, 40, 2, 2, 5, np);
        check("t5_after_plot_count", np, 4);
        end_check(1'b0);

        // Test 6: reset in the middle of a fill with one command queued.
        offer(0, 0, 20, 20, 3);
        tick();
        offer(5, 5, 2, 2, 1);
        tick();
        cmd_valid = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_rst_xyc", {13'd0, x, y, colour}, 32'd0);
        check("t6_rst_plot_done_busy", {29'd0, plot, done, busy}, 32'd0);
        check("t6_rst_ready", {31'd0, cmd_ready}, 32'd1);
        plots = 0;
        dones = 0;
        n     = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (plot) plots++;
            if (done) dones++;
            if (busy) n++;
        end
        check("t6_quiet_plots", plots, 0);
        check("t6_quiet_dones", dones, 0);
        check("t6_queue_empty", n, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
